// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: shift-op codes, FSM states, default widths.
package alu_pkg;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    localparam logic [1:0] SH_PASS = 2'b00;
    localparam logic [1:0] SH_SHR  = 2'b01;
    localparam logic [1:0] SH_SHL  = 2'b10;
    localparam logic [1:0] SH_OP3  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/alu_result_shifter_if.sv
// Valid/ready bundle between the ALU, the result shifter and its consumer.
interface alu_result_shifter_if #(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = alu_pkg::CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_word;
    logic             alu_cout;
    logic [1:0]       shift_op;
    logic [CNT_W-1:0] shift_cnt;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_c;
    logic             flag_z;
    logic             flag_s;
    logic             busy;

    modport master (
        output in_valid, alu_word, alu_cout, shift_op, shift_cnt, out_ready,
        input  in_ready, out_valid, result, flag_c, flag_z, flag_s, busy
    );

    modport slave (
        input  in_valid, alu_word, alu_cout, shift_op, shift_cnt, out_ready,
        output in_ready, out_valid, result, flag_c, flag_z, flag_s, busy
    );
endinterface

// File: rtl/alu_result_shifter_shift_step.sv
// Combinational single-bit shifter. Op 11 is rotate-through-carry when SHIFT_ROTATE_EN
// is defined, arithmetic shift right otherwise.
module shift_step
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic [WIDTH-1:0] acc,
    input  logic             c_in,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] acc_next,
    output logic             c_next
);

    always_comb begin
        acc_next = acc;
        c_next   = c_in;
        case (op)
            SH_SHR: begin
                acc_next = {1'b0, acc[WIDTH-1:1]};
                c_next   = acc[0];
            end
            SH_SHL: begin
                acc_next = {acc[WIDTH-2:0], 1'b0};
                c_next   = acc[WIDTH-1];
            end
            SH_OP3: begin
`ifdef SHIFT_ROTATE_EN
                acc_next = {c_in, acc[WIDTH-1:1]};
`else
                acc_next = {acc[WIDTH-1], acc[WIDTH-1:1]};
`endif
                c_next   = acc[0];
            end
            default: begin
                acc_next = acc;
                c_next   = c_in;
            end
        endcase
    end

endmodule

// File: rtl/alu_result_shifter.sv
// ALU result stage: captures word/carry, shifts one bit per clock, then presents result and
// C/Z/S flags until the consumer accepts. Op 11 behaviour selected by SHIFT_ROTATE_EN.
module alu_result_shifter
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH,
    parameter int CNT_W = alu_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_result_shifter_if.slave bus
);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] acc;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       op;
    logic             flag_c_q;
    logic             flag_z_q;
    logic             flag_s_q;

    logic [WIDTH-1:0] step_acc;
    logic             step_c;
    logic [WIDTH-1:0] fin_acc;
    logic             fin_c;
    logic             enter_done;
    logic             accept;

    shift_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc),
        .c_in     (c_reg),
        .op       (op),
        .acc_next (step_acc),
        .c_next   (step_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.in_valid)
                    next_state = (bus.shift_op == SH_PASS || bus.shift_cnt == '0) ? DONE : SHIFT;
            end
            SHIFT: begin
                if (cnt == CNT_W'(1)) next_state = DONE;
            end
            DONE: begin
                if (bus.out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.out_valid = (state == DONE);
        bus.busy      = (state != IDLE);
    end

    assign accept     = (state == IDLE) && bus.in_valid;
    assign enter_done = (state != DONE) && (next_state == DONE);
    // Flags come from whatever acc/carry will be on entry to DONE: raw ALU values on a
    // direct pass, or the output of the last shift step.
    assign fin_acc    = (state == IDLE) ? bus.alu_word : step_acc;
    assign fin_c      = (state == IDLE) ? bus.alu_cout : step_c;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc      <= '0;
            c_reg    <= 1'b0;
            cnt      <= '0;
            op       <= SH_PASS;
            flag_c_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_s_q <= 1'b0;
        end else begin
            if (accept) begin
                acc   <= bus.alu_word;
                c_reg <= bus.alu_cout;
                op    <= bus.shift_op;
                cnt   <= bus.shift_cnt;
            end else if (state == SHIFT) begin
                acc   <= step_acc;
                c_reg <= step_c;
                cnt   <= cnt - 1'b1;
            end
            if (enter_done) begin
                flag_c_q <= fin_c;
                flag_z_q <= (fin_acc == '0);
                flag_s_q <= fin_acc[WIDTH-1];
            end
        end
    end

    assign bus.result = acc;
    assign bus.flag_c = flag_c_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_s = flag_s_q;

endmodule

// File: tb/tb_alu_result_shifter.sv
// Directed bench for alu_result_shifter: vector table plus stall and mid-shift reset sequences.
module tb_alu_result_shifter;
    import alu_pkg::*;

    typedef struct {
        logic [3:0] word;
        logic       cout;
        logic [1:0] op;
        logic [1:0] cnt;
        logic [3:0] exp_res;
        logic       exp_c;
        logic       exp_z;
        logic       exp_s;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    alu_result_shifter_if #(.WIDTH(4), .CNT_W(2)) bus ();

    alu_result_shifter #(.WIDTH(4), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one transaction, scrambles the inputs afterwards, and counts edges to out_valid.
    task automatic applyStimulus(input vec_t v, output int lat);
        bus.alu_word  = v.word;
        bus.alu_cout  = v.cout;
        bus.shift_op  = v.op;
        bus.shift_cnt = v.cnt;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        bus.alu_word  = ~v.word;
        bus.alu_cout  = ~v.cout;
        bus.shift_op  = ~v.op;
        bus.shift_cnt = ~v.cnt;
        lat = 1;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic releaseResult();
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen_valid;

        vecs[0] = '{4'b1011, 1'b1, 2'b00, 2'd2, 4'b1011, 1'b1, 1'b0, 1'b1, 1};
        vecs[1] = '{4'b0110, 1'b0, 2'b10, 2'd3, 4'b0000, 1'b1, 1'b1, 1'b0, 4};
        vecs[2] = '{4'b0001, 1'b0, 2'b01, 2'd1, 4'b0000, 1'b1, 1'b1, 1'b0, 2};
`ifdef SHIFT_ROTATE_EN
        vecs[3] = '{4'b1000, 1'b1, 2'b11, 2'd2, 4'b0110, 1'b0, 1'b0, 1'b0, 3};
        vecs[6] = '{4'b1001, 1'b0, 2'b11, 2'd3, 4'b0101, 1'b0, 1'b0, 1'b0, 4};
`else
        vecs[3] = '{4'b1000, 1'b1, 2'b11, 2'd2, 4'b1110, 1'b0, 1'b0, 1'b1, 3};
        vecs[6] = '{4'b1001, 1'b0, 2'b11, 2'd3, 4'b1111, 1'b0, 1'b0, 1'b1, 4};
`endif
        vecs[4] = '{4'b0101, 1'b1, 2'b10, 2'd0, 4'b0101, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{4'b1111, 1'b0, 2'b01, 2'd3, 4'b0001, 1'b1, 1'b0, 1'b0, 4};
        vecs[7] = '{4'b0000, 1'b0, 2'b00, 2'd0, 4'b0000, 1'b0, 1'b1, 1'b0, 1};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.alu_word  = 4'h0;
        bus.alu_cout  = 1'b0;
        bus.shift_op  = 2'b00;
        bus.shift_cnt = 2'd0;
        tick();
        tick();
        rst_n = 1'b1;

        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset result", 32'(bus.result), 32'd0);
        checkOutput("reset flags", 32'({bus.flag_c, bus.flag_z, bus.flag_s}), 32'd0);

        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            checkOutput($sformatf("v%0d result", i), 32'(bus.result), 32'(vecs[i].exp_res));
            checkOutput($sformatf("v%0d flags czs", i),
                        32'({bus.flag_c, bus.flag_z, bus.flag_s}),
                        32'({vecs[i].exp_c, vecs[i].exp_z, vecs[i].exp_s}));
            checkOutput($sformatf("v%0d busy/in_ready", i),
                        32'({bus.busy, bus.in_ready}), 32'b10);
            releaseResult();
            checkOutput($sformatf("v%0d after release", i),
                        32'({bus.out_valid, bus.in_ready, bus.busy}), 32'b010);
        end

        // Consumer stalls while new inputs keep arriving: result must hold, inputs must drop.
        applyStimulus(vecs[0], lat);
        checkOutput("stall latency", 32'(lat), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid  = i[0];
            bus.alu_word  = 4'b0000;
            bus.alu_cout  = 1'b0;
            bus.shift_op  = 2'b10;
            bus.shift_cnt = 2'd1;
            tick();
            checkOutput($sformatf("stall hold %0d", i),
                        32'({bus.result, bus.flag_c, bus.flag_z, bus.flag_s}),
                        32'({4'b1011, 1'b1, 1'b0, 1'b1}));
            checkOutput($sformatf("stall ctl %0d", i),
                        32'({bus.out_valid, bus.in_ready}), 32'b10);
        end
        bus.in_valid = 1'b0;
        releaseResult();
        checkOutput("stall release", 32'({bus.out_valid, bus.in_ready}), 32'b01);
        tick();
        checkOutput("stall nothing queued", 32'({bus.out_valid, bus.busy}), 32'b00);

        // Reset while shifting discards the transaction entirely.
        bus.alu_word  = 4'b0110;
        bus.alu_cout  = 1'b1;
        bus.shift_op  = 2'b10;
        bus.shift_cnt = 2'd3;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid  = 1'b0;
        checkOutput("midreset shifting", 32'({bus.busy, bus.in_ready, bus.out_valid}), 32'b100);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("midreset ctl", 32'({bus.in_ready, bus.out_valid, bus.busy}), 32'b100);
        checkOutput("midreset result", 32'(bus.result), 32'd0);
        checkOutput("midreset flags", 32'({bus.flag_c, bus.flag_z, bus.flag_s}), 32'd0);
        seen_valid = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.out_valid) seen_valid++;
        end
        checkOutput("midreset no result", 32'(seen_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
